// File: rtl/mhsa_dma_pkg.sv
// rtl/mhsa_dma_pkg.sv - shared state type, size defaults and address-wrap helper for the MHSA host DMA
package mhsa_dma_pkg;

  localparam int DMA_WIDTH  = 64;
  localparam int DMA_LENGTH = 4096;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    KICK,
    WAIT,
    DRAIN
  } dma_state_t;

  // (base + offset) folded back into [0, length); callers keep base < length and offset < length
  function automatic int unsigned wrap_addr(input int unsigned base,
                                            input int unsigned offset,
                                            input int unsigned length);
    int unsigned sum;
    sum = base + offset;
    return (sum >= length) ? (sum - length) : sum;
  endfunction

endpackage

// File: rtl/mhsa_host_dma_if.sv
// rtl/mhsa_host_dma_if.sv - descriptor, stream, accelerator-control and memory-port bundle for the MHSA host DMA
interface mhsa_host_dma_if
  import mhsa_dma_pkg::*;
#(
  parameter int WIDTH  = DMA_WIDTH,
  parameter int LENGTH = DMA_LENGTH
) ();

  localparam int ADDR_W = $clog2(LENGTH);

  // job descriptor
  logic              cfg_valid;
  logic              cfg_ready;
  logic [ADDR_W-1:0] cfg_in_base;
  logic [ADDR_W-1:0] cfg_out_base;
  logic [ADDR_W:0]   cfg_in_words;
  logic [ADDR_W:0]   cfg_out_words;

  // input word stream
  logic              s_valid;
  logic              s_ready;
  logic [WIDTH-1:0]  s_data;

  // result stream
  logic              m_valid;
  logic              m_ready;
  logic [WIDTH-1:0]  m_data;
  logic              m_last;

  // accelerator control
  logic              acc_start;
  logic              acc_done;
  logic [ADDR_W-1:0] acc_input_base;
  logic [ADDR_W-1:0] acc_output_base;

  // accelerator memory port
  logic              soc_write_en;
  logic [ADDR_W-1:0] soc_addr;
  logic [WIDTH-1:0]  soc_data_in;
  logic [WIDTH-1:0]  soc_data_out;

  // DMA side
  modport master (
    input  cfg_valid, cfg_in_base, cfg_out_base, cfg_in_words, cfg_out_words,
    output cfg_ready,
    input  s_valid, s_data,
    output s_ready,
    output m_valid, m_data, m_last,
    input  m_ready,
    output acc_start, acc_input_base, acc_output_base,
    input  acc_done,
    output soc_write_en, soc_addr, soc_data_in,
    input  soc_data_out
  );

  // host / accelerator side
  modport slave (
    output cfg_valid, cfg_in_base, cfg_out_base, cfg_in_words, cfg_out_words,
    input  cfg_ready,
    output s_valid, s_data,
    input  s_ready,
    input  m_valid, m_data, m_last,
    output m_ready,
    input  acc_start, acc_input_base, acc_output_base,
    output acc_done,
    input  soc_write_en, soc_addr, soc_data_in,
    output soc_data_out
  );

endinterface

// File: rtl/mhsa_dma_rdfifo.sv
// rtl/mhsa_dma_rdfifo.sv - 2-entry read-return FIFO buffering accelerator memory reads during drain
module mhsa_dma_rdfifo
  import mhsa_dma_pkg::*;
#(
  parameter int WIDTH = DMA_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [1:0]       count,
  output logic             empty
);

  logic [WIDTH-1:0] mem0_q;
  logic [WIDTH-1:0] mem1_q;
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic [1:0]       count_q;

  // storage, pointers and occupancy; caller guarantees no push when full and no pop when empty
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem0_q   <= '0;
      mem1_q   <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push) begin
        if (wr_ptr_q) mem1_q <= push_data;
        else          mem0_q <= push_data;
        wr_ptr_q <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      case ({push, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign head  = rd_ptr_q ? mem1_q : mem0_q;
  assign count = count_q;
  assign empty = (count_q == 2'd0);

endmodule

// File: rtl/mhsa_host_dma.sv
// rtl/mhsa_host_dma.sv - MHSA host DMA: load input words, kick accelerator, drain results; MHSA_DMA_TIMEOUT_EN adds a WAIT watchdog
module mhsa_host_dma
  import mhsa_dma_pkg::*;
#(
  parameter int WIDTH   = DMA_WIDTH,
  parameter int LENGTH  = DMA_LENGTH,
  parameter int TIMEOUT = 1 << 20
) (
  input  logic            clk,
  input  logic            rst,
  mhsa_host_dma_if.master bus,
  output logic            busy,
  output logic            err
);

  localparam int ADDR_W = $clog2(LENGTH);
  localparam int CW     = ADDR_W + 1;

  dma_state_t state_q, state_d;

  logic [ADDR_W-1:0] in_base_q, out_base_q;
  logic [CW-1:0]     in_words_q, out_words_q;
  logic [CW-1:0]     idx_q;      // words written in LOAD
  logic [CW-1:0]     ridx_q;     // reads issued in DRAIN
  logic [CW-1:0]     ocnt_q;     // words handed out on the result stream
  logic              rd_pend_q;  // a read was issued last cycle; its data is on soc_data_out now

  logic              accept;
  logic              wr_en, rd_issue, pop;
  logic              s_ready_c, acc_start_c, m_last_c;
  logic [ADDR_W-1:0] soc_addr_c;
  logic [WIDTH-1:0]  soc_data_c;

  logic [WIDTH-1:0]  fifo_head;
  logic [1:0]        fifo_count;
  logic              fifo_empty;
  logic              m_valid_c;

`ifdef MHSA_DMA_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] wait_cnt_q;
  logic          timeout_hit;
  logic          err_q;
`endif

  assign accept    = (state_q == IDLE) && bus.cfg_valid;
  assign m_valid_c = (state_q == DRAIN) && !fifo_empty;
  assign pop       = m_valid_c && bus.m_ready;
  assign m_last_c  = m_valid_c && ((ocnt_q + CW'(1)) == out_words_q);

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // next-state and per-cycle memory-port / handshake decode
  always_comb begin
    state_d     = state_q;
    s_ready_c   = 1'b0;
    acc_start_c = 1'b0;
    wr_en       = 1'b0;
    rd_issue    = 1'b0;
    soc_addr_c  = '0;
    soc_data_c  = '0;
`ifdef MHSA_DMA_TIMEOUT_EN
    timeout_hit = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (bus.cfg_valid) state_d = (bus.cfg_in_words == '0) ? KICK : LOAD;
      end
      LOAD: begin
        s_ready_c = 1'b1;
        if (bus.s_valid) begin
          wr_en      = 1'b1;
          soc_addr_c = ADDR_W'(wrap_addr(32'(in_base_q), 32'(idx_q), LENGTH));
          soc_data_c = bus.s_data;
          if ((idx_q + CW'(1)) == in_words_q) state_d = KICK;
        end
      end
      KICK: begin
        acc_start_c = 1'b1;
        state_d     = WAIT;
      end
      WAIT: begin
        if (bus.acc_done) begin
          state_d = (out_words_q == '0) ? IDLE : DRAIN;
        end
`ifdef MHSA_DMA_TIMEOUT_EN
        else if (wait_cnt_q == TW'(TIMEOUT - 1)) begin
          timeout_hit = 1'b1;
          state_d     = IDLE;
        end
`endif
      end
      DRAIN: begin
        // a word popped this cycle frees a slot, which keeps one read per cycle under full flow
        if ((ridx_q < out_words_q) &&
            ((32'(rd_pend_q) + 32'(fifo_count)) < (32'd2 + 32'(pop)))) begin
          rd_issue   = 1'b1;
          soc_addr_c = ADDR_W'(wrap_addr(32'(out_base_q), 32'(ridx_q), LENGTH));
        end
        if (pop && m_last_c) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // descriptor latch and transfer counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_base_q   <= '0;
      out_base_q  <= '0;
      in_words_q  <= '0;
      out_words_q <= '0;
      idx_q       <= '0;
      ridx_q      <= '0;
      ocnt_q      <= '0;
      rd_pend_q   <= 1'b0;
    end else begin
      if (accept) begin
        in_base_q   <= bus.cfg_in_base;
        out_base_q  <= bus.cfg_out_base;
        in_words_q  <= bus.cfg_in_words;
        out_words_q <= bus.cfg_out_words;
        idx_q       <= '0;
        ridx_q      <= '0;
        ocnt_q      <= '0;
      end
      if (wr_en)    idx_q  <= idx_q + CW'(1);
      if (rd_issue) ridx_q <= ridx_q + CW'(1);
      if (pop)      ocnt_q <= ocnt_q + CW'(1);
      rd_pend_q <= rd_issue;
    end
  end

`ifdef MHSA_DMA_TIMEOUT_EN
  // WAIT watchdog and sticky error; a new descriptor clears the error
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      if (state_q == WAIT) wait_cnt_q <= wait_cnt_q + TW'(1);
      else                 wait_cnt_q <= '0;
      if (accept)           err_q <= 1'b0;
      else if (timeout_hit) err_q <= 1'b1;
    end
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  mhsa_dma_rdfifo #(.WIDTH(WIDTH)) u_rdfifo (
    .clk      (clk),
    .rst      (rst),
    .push     (rd_pend_q),
    .push_data(bus.soc_data_out),
    .pop      (pop),
    .head     (fifo_head),
    .count    (fifo_count),
    .empty    (fifo_empty)
  );

  // cfg_ready is held low while reset is asserted so every output reads 0 during reset
  assign bus.cfg_ready       = (state_q == IDLE) && !rst;
  assign bus.s_ready         = s_ready_c;
  assign bus.m_valid         = m_valid_c;
  assign bus.m_data          = fifo_head;
  assign bus.m_last          = m_last_c;
  assign bus.acc_start       = acc_start_c;
  assign bus.acc_input_base  = in_base_q;
  assign bus.acc_output_base = out_base_q;
  assign bus.soc_write_en    = wr_en;
  assign bus.soc_addr        = soc_addr_c;
  assign bus.soc_data_in     = soc_data_c;
  assign busy                = (state_q != IDLE);

endmodule

// File: tb/tb_mhsa_host_dma.sv
// tb/tb_mhsa_host_dma.sv - self-checking bench for mhsa_host_dma with accelerator memory model and reference memory
module tb_mhsa_host_dma;

  localparam int L = 4096;
`ifdef MHSA_DMA_TIMEOUT_EN
  localparam int TB_TIMEOUT = 64;
`else
  localparam int TB_TIMEOUT = 1 << 20;
`endif

  logic clk = 1'b0;
  logic rst;
  logic busy, err;
  int   total = 0;
  int   bad   = 0;

  logic [63:0] mem     [0:L-1];
  logic [63:0] ref_mem [0:L-1];
  logic [63:0] in_q[$];

  mhsa_host_dma_if #(.WIDTH(64), .LENGTH(L)) bus ();

  mhsa_host_dma #(.WIDTH(64), .LENGTH(L), .TIMEOUT(TB_TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master),
    .busy(busy),
    .err (err)
  );

  always #5 clk = ~clk;

  // accelerator memory: synchronous write, registered read one cycle after the address
  always @(posedge clk) begin
    if (bus.soc_write_en) mem[bus.soc_addr] = bus.soc_data_in;
    bus.soc_data_out <= mem[bus.soc_addr];
  end

  function automatic logic mr_val(input int mode, input int k);
    if (mode == 0) return 1'b1;
    if (mode == 1) return ((k % 4) == 0) || ((k % 4) == 3);
    return 1'($urandom_range(0, 1));
  endfunction

  // mode: 0 = m_ready/s_valid held high, 1 = m_ready 1,0,0,1, 2 = random gaps
  task automatic run_job(input int ib, input int ob, input int iw, input int ow, input int delay,
                         input int mode, input bit early_done, input int stop_after);
    logic [63:0] exp_q[$];
    int i, j, k, cyc, first_hs, last_hs, wr_seen;
    @(negedge clk);
    bus.cfg_valid     = 1'b1;
    bus.cfg_in_base   = 12'(ib);
    bus.cfg_out_base  = 12'(ob);
    bus.cfg_in_words  = 13'(iw);
    bus.cfg_out_words = 13'(ow);
    #1;
    total++;
    if (bus.cfg_ready !== 1'b1) begin bad++; $display("FAIL accept_ready got=%0b want=1", bus.cfg_ready); end
    for (i = 0; i < iw; i++) ref_mem[(ib + i) % L] = in_q[i];
    for (j = 0; j < ow; j++) exp_q.push_back(ref_mem[(ob + j) % L]);
    @(negedge clk);
    bus.cfg_valid = 1'b0;
    i = 0; cyc = 0;
    while (i < iw && cyc < 1000) begin
      bus.s_valid = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.s_data  = in_q[i];
      #1;
      total++;
      if (bus.s_valid) begin
        if (bus.s_ready !== 1'b1 || bus.soc_write_en !== 1'b1 || bus.soc_addr !== 12'((ib + i) % L) ||
            bus.soc_data_in !== in_q[i]) begin
          bad++;
          $display("FAIL load_write%0d got we=%0b addr=%h data=%h want we=1 addr=%h data=%h",
                   i, bus.soc_write_en, bus.soc_addr, bus.soc_data_in, 12'((ib + i) % L), in_q[i]);
        end
        i++;
      end else if (bus.soc_write_en !== 1'b0) begin
        bad++; $display("FAIL load_idle_write got=%0b want=0", bus.soc_write_en);
      end
      @(negedge clk); cyc++;
    end
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    if (cyc >= 1000) begin total++; bad++; $display("FAIL load_budget got=%0d want<1000", cyc); end
    #1;
    total++;
    if (bus.acc_start !== 1'b1 || busy !== 1'b1 || bus.s_ready !== 1'b0 || bus.soc_write_en !== 1'b0 ||
        bus.acc_input_base !== 12'(ib) || bus.acc_output_base !== 12'(ob)) begin
      bad++;
      $display("FAIL kick got start=%0b busy=%0b we=%0b ib=%h ob=%h want start=1 busy=1 we=0 ib=%h ob=%h",
               bus.acc_start, busy, bus.soc_write_en, bus.acc_input_base, bus.acc_output_base,
               12'(ib), 12'(ob));
    end
    if (early_done) bus.acc_done = 1'b1;
    for (int c = 0; c < delay; c++) begin
      @(negedge clk); #1;
      total++;
      if (busy !== 1'b1 || bus.acc_start !== 1'b0 || bus.m_valid !== 1'b0) begin
        bad++; $display("FAIL wait_hold got busy=%0b start=%0b mv=%0b want 1 0 0", busy, bus.acc_start, bus.m_valid);
      end
    end
    @(negedge clk);
    bus.acc_done = 1'b1;
    #1;
    total++;
    if (busy !== 1'b1 || bus.acc_start !== 1'b0) begin
      bad++; $display("FAIL wait_done got busy=%0b start=%0b want 1 0", busy, bus.acc_start);
    end
    @(negedge clk);
    bus.acc_done = 1'b0;
    if (ow == 0) begin
      #1;
      total++;
      if (busy !== 1'b0 || bus.cfg_ready !== 1'b1) begin
        bad++; $display("FAIL zero_out_idle got busy=%0b rdy=%0b want 0 1", busy, bus.cfg_ready);
      end
      return;
    end
    j = 0; k = 0; first_hs = -1; last_hs = -1; wr_seen = 0;
    bus.m_ready = mr_val(mode, k);
    #1;
    while (1) begin
      if (bus.soc_write_en) wr_seen++;
      if (bus.m_valid && bus.m_ready) begin
        total++;
        if (bus.m_data !== exp_q[j] || bus.m_last !== (j == ow - 1)) begin
          bad++;
          $display("FAIL drain_word%0d got data=%h last=%0b want data=%h last=%0b",
                   j, bus.m_data, bus.m_last, exp_q[j], (j == ow - 1));
        end
        if (first_hs < 0) first_hs = k;
        last_hs = k;
        j++;
        if (stop_after > 0 && j == stop_after) begin
          @(negedge clk);
          bus.m_ready = 1'b0;
          rst = 1'b1;
          #1;
          total++;
          if ({busy, err, bus.cfg_ready, bus.s_ready, bus.m_valid, bus.m_last, bus.acc_start,
               bus.soc_write_en} !== 8'b0 || bus.soc_addr !== '0 || bus.m_data !== '0 ||
              bus.soc_data_in !== '0 || bus.acc_input_base !== '0 || bus.acc_output_base !== '0) begin
            bad++;
            $display("FAIL reset_mid_drain got busy=%0b mv=%0b we=%0b addr=%h data=%h want all 0",
                     busy, bus.m_valid, bus.soc_write_en, bus.soc_addr, bus.m_data);
          end
          @(negedge clk);
          rst = 1'b0;
          return;
        end
      end
      if (j == ow || k > 40 * ow + 40) break;
      @(negedge clk);
      k++;
      bus.m_ready = mr_val(mode, k);
      #1;
    end
    total++;
    if (j != ow) begin bad++; $display("FAIL drain_count got=%0d want=%0d", j, ow); end
    total++;
    if (wr_seen != 0) begin bad++; $display("FAIL drain_writes got=%0d want=0", wr_seen); end
    if (mode == 0) begin
      total++;
      if (last_hs - first_hs != ow - 1) begin
        bad++; $display("FAIL drain_rate got span=%0d want=%0d", last_hs - first_hs, ow - 1);
      end
    end
    @(negedge clk);
    bus.m_ready = 1'b0;
    #1;
    total++;
    if (busy !== 1'b0 || bus.m_valid !== 1'b0 || bus.cfg_ready !== 1'b1) begin
      bad++; $display("FAIL drain_exit got busy=%0b mv=%0b rdy=%0b want 0 0 1", busy, bus.m_valid, bus.cfg_ready);
    end
  endtask

  task automatic fill_in(input int n);
    in_q.delete();
    for (int i = 0; i < n; i++) in_q.push_back({$urandom, $urandom});
  endtask

  task automatic test_reset;
    #1;
    total++;
    if ({busy, err, bus.cfg_ready, bus.s_ready, bus.m_valid, bus.m_last, bus.acc_start,
         bus.soc_write_en} !== 8'b0 || bus.soc_addr !== '0) begin
      bad++; $display("FAIL reset_outputs got busy=%0b rdy=%0b we=%0b want all 0", busy, bus.cfg_ready, bus.soc_write_en);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++;
    if (bus.cfg_ready !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("FAIL reset_release got rdy=%0b busy=%0b want 1 0", bus.cfg_ready, busy);
    end
  endtask

  task automatic test_basic;
    in_q = '{64'h11, 64'h22, 64'h33, 64'h44};
    run_job(12'h000, 12'h100, 4, 4, 10, 0, 1'b0, 0);
    in_q = '{64'h11, 64'h22, 64'h33, 64'h44};
    run_job(12'h180, 12'h180, 4, 4, 2, 0, 1'b0, 0);
  endtask

  task automatic test_wrap;
    fill_in(4);
    run_job(12'hFFE, 12'hFFD, 4, 5, 3, 0, 1'b0, 0);
  endtask

  task automatic test_backpressure;
    fill_in(8);
    run_job(12'h200, 12'h200, 8, 8, 4, 1, 1'b0, 0);
  endtask

  task automatic test_zero_length;
    in_q.delete();
    run_job(12'h010, 12'h020, 0, 0, 4, 0, 1'b0, 0);
    run_job(12'h010, 12'h020, 0, 0, 0, 0, 1'b1, 0);
    run_job(12'h010, 12'hFFF, 0, 2, 0, 0, 1'b1, 0);
  endtask

  task automatic test_reset_mid_drain;
    fill_in(8);
    run_job(12'h300, 12'h300, 8, 8, 2, 0, 1'b0, 3);
    fill_in(8);
    run_job(12'h400, 12'h300, 8, 8, 2, 0, 1'b0, 0);
  endtask

  task automatic test_back_to_back;
    for (int n = 0; n < 8; n++) begin
      int ib, ob, iw, ow;
      iw = $urandom_range(0, 12);
      ow = $urandom_range(0, 12);
      ib = $urandom_range(0, L - 1);
      ob = ($urandom_range(0, 1) != 0) ? ib : $urandom_range(0, L - 1);
      fill_in(iw);
      run_job(ib, ob, iw, ow, $urandom_range(0, 5), 2, 1'b0, 0);
    end
  endtask

`ifdef MHSA_DMA_TIMEOUT_EN
  task automatic test_timeout;
    int cnt;
    @(negedge clk);
    bus.cfg_valid     = 1'b1;
    bus.cfg_in_base   = 12'h0;
    bus.cfg_out_base  = 12'h0;
    bus.cfg_in_words  = 13'd0;
    bus.cfg_out_words = 13'd4;
    @(negedge clk);
    bus.cfg_valid = 1'b0;
    cnt = 0;
    do begin
      @(negedge clk); #1; cnt++;
    end while (busy && cnt < 200);
    total++;
    if (cnt - 1 != 64 || err !== 1'b1 || bus.m_valid !== 1'b0) begin
      bad++; $display("FAIL timeout got wait=%0d err=%0b want wait=64 err=1", cnt - 1, err);
    end
    in_q.delete();
    run_job(12'h0, 12'h0, 0, 0, 1, 0, 1'b0, 0);
    total++;
    if (err !== 1'b0) begin bad++; $display("FAIL timeout_clear got err=%0b want=0", err); end
  endtask
`endif

  initial begin
    rst = 1'b1;
    bus.cfg_valid = 1'b0; bus.cfg_in_base = '0; bus.cfg_out_base = '0;
    bus.cfg_in_words = '0; bus.cfg_out_words = '0;
    bus.s_valid = 1'b0; bus.s_data = '0; bus.m_ready = 1'b0; bus.acc_done = 1'b0;
    for (int a = 0; a < L; a++) begin
      mem[a]     = {$urandom, $urandom};
      ref_mem[a] = mem[a];
    end
    repeat (3) @(negedge clk);
    test_reset;
    test_basic;
    test_wrap;
    test_backpressure;
    test_zero_length;
    test_reset_mid_drain;
    test_back_to_back;
`ifdef MHSA_DMA_TIMEOUT_EN
    test_timeout;
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
